osc_cmd_decoder: RTL and testbench

OSC_CMD_DECODER -- requirements
Module: osc_cmd_decoder

---
 rtl/osc_cmd_pkg.sv | 32 +++
 rtl/osc_cmd_edge.sv | 34 +++
 rtl/osc_cmd_decoder.sv | 182 ++++++++++++++++++
 tb/tb_osc_cmd_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/osc_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osc_cmd_pkg
// Description : Shared constants for the oscillator command decoder: field
//               widths of the 16-bit SPI command word, register address map
//               and the soft-reset key.
// Revision    : 1.0 - initial release
// ============================================================================
package osc_cmd_pkg;

    // Field widths of the command word and of the oscillator registers
    localparam int ADDR_W = 4;
    localparam int VAL_W  = 12;
    localparam int FREQ_W = 24;
    localparam int WAVE_W = 2;
    localparam int WORD_W = ADDR_W + VAL_W;
    localparam int ERR_W  = 8;

    // Register address map (upper nibble of the command word)
    localparam logic [ADDR_W-1:0] ADDR_NOP      = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_FREQ_LO  = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_FREQ_HI  = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_WAVE     = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_AMP      = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_SYNC     = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_SOFT_RST = 4'hF;

    // Value that must accompany ADDR_SOFT_RST for the soft reset to take effect
    localparam logic [VAL_W-1:0]  SOFT_RST_KEY  = 12'hA5A;

endpackage : osc_cmd_pkg
`default_nettype wire

// File: rtl/osc_cmd_edge.sv
`default_nettype none
// ============================================================================
// Module      : osc_cmd_edge
// Description : Rising-edge detector for the SPI receiver's data_valid level.
//               The delayed copy resets to 1 so a data_valid that is already
//               high when reset is released is not seen as a new word.
// Ports       : clock      - system clock, rising edge
//               reset      - asynchronous, active-high
//               data_valid - level from the SPI receiver
//               rise       - high for the cycle data_valid=1 and the delayed
//                            copy is 0 (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module osc_cmd_edge (
    input  logic clock,
    input  logic reset,
    input  logic data_valid,
    output logic rise
);

    logic r_data_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_valid_q <= 1'b1;
        end else begin
            r_data_valid_q <= data_valid;
        end
    end

    assign rise = data_valid & ~r_data_valid_q;

endmodule : osc_cmd_edge
`default_nettype wire

// File: rtl/osc_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : osc_cmd_decoder
// Description : Decodes 16-bit SPI command words ({addr[3:0], value[11:0]})
//               into oscillator control registers. Stage 1 captures a word on
//               each data_valid rising edge, stage 2 decodes it, so register
//               outputs change two clocks after data_valid is first sampled.
// Build macro : OSC_CMD_ERRCNT_EN - when defined, err_count counts invalid
//               commands (saturating at 8'hFF); otherwise it is tied to 0.
// Ports       : clock        - system clock, rising edge
//               reset        - asynchronous, active-high
//               data_in      - received SPI word, stable while data_valid=1
//               data_valid   - level from SPI receiver, rising edge = new word
//               freq_inc     - oscillator phase increment
//               wave_sel     - waveform select
//               amplitude    - output amplitude
//               phase_reset  - one-clock phase accumulator clear request
//               param_update - one-clock pulse with any newly written value
//               err_count    - number of invalid commands
// Revision    : 1.0 - initial release
// ============================================================================
module osc_cmd_decoder
    import osc_cmd_pkg::*;
#(
    parameter logic [FREQ_W-1:0] DEF_FREQ = 24'h00_1000,
    parameter logic [VAL_W-1:0]  DEF_AMP  = 12'hFFF,
    parameter logic [WAVE_W-1:0] DEF_WAVE = 2'b00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic [FREQ_W-1:0] freq_inc,
    output logic [WAVE_W-1:0] wave_sel,
    output logic [VAL_W-1:0]  amplitude,
    output logic              phase_reset,
    output logic              param_update,
    output logic [ERR_W-1:0]  err_count
);

    // ------------------------------------------------------------------------
    // Stage 1: edge detect and word capture
    // ------------------------------------------------------------------------
    logic              w_rise;
    logic [WORD_W-1:0] r_cmd_word;
    logic              r_cmd_valid;

    osc_cmd_edge u_edge (
        .clock      (clock),
        .reset      (reset),
        .data_valid (data_valid),
        .rise       (w_rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd_word  <= '0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_cmd_valid <= w_rise;
            if (w_rise) begin
                r_cmd_word <= data_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: command decode
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr;
    logic [VAL_W-1:0]  w_value;
    logic              w_key_ok;
    logic              w_wr_lo;
    logic              w_wr_hi;
    logic              w_wr_wave;
    logic              w_wr_amp;
    logic              w_sync;
    logic              w_soft_rst;

    assign w_addr   = r_cmd_word[WORD_W-1:VAL_W];
    assign w_value  = r_cmd_word[VAL_W-1:0];
    assign w_key_ok = (w_value == SOFT_RST_KEY);

    always_comb begin
        w_wr_lo    = 1'b0;
        w_wr_hi    = 1'b0;
        w_wr_wave  = 1'b0;
        w_wr_amp   = 1'b0;
        w_sync     = 1'b0;
        w_soft_rst = 1'b0;
        if (r_cmd_valid) begin
            case (w_addr)
                ADDR_FREQ_LO:  w_wr_lo    = 1'b1;
                ADDR_FREQ_HI:  w_wr_hi    = 1'b1;
                ADDR_WAVE:     w_wr_wave  = 1'b1;
                ADDR_AMP:      w_wr_amp   = 1'b1;
                ADDR_SYNC:     w_sync     = 1'b1;
                ADDR_SOFT_RST: w_soft_rst = w_key_ok;
                default:       ;  // NOP and unmapped addresses: no action
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    logic [VAL_W-1:0]  r_lo_shadow;
    logic [FREQ_W-1:0] r_freq_inc;
    logic [WAVE_W-1:0] r_wave_sel;
    logic [VAL_W-1:0]  r_amplitude;
    logic              r_phase_reset;
    logic              r_param_update;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lo_shadow    <= '0;
            r_freq_inc     <= DEF_FREQ;
            r_wave_sel     <= DEF_WAVE;
            r_amplitude    <= DEF_AMP;
            r_phase_reset  <= 1'b0;
            r_param_update <= 1'b0;
        end else begin
            r_phase_reset  <= w_sync;
            // Equal-value writes still pulse: the pulse marks a write, not a change
            r_param_update <= w_wr_hi | w_wr_wave | w_wr_amp | w_soft_rst;

            if (w_soft_rst) begin
                r_lo_shadow <= '0;
                r_freq_inc  <= DEF_FREQ;
                r_wave_sel  <= DEF_WAVE;
                r_amplitude <= DEF_AMP;
            end else begin
                if (w_wr_lo) begin
                    r_lo_shadow <= w_value;
                end
                // Low half comes from the shadow so both halves change together
                if (w_wr_hi) begin
                    r_freq_inc <= {w_value, r_lo_shadow};
                end
                if (w_wr_wave) begin
                    r_wave_sel <= w_value[WAVE_W-1:0];
                end
                if (w_wr_amp) begin
                    r_amplitude <= w_value;
                end
            end
        end
    end

    assign freq_inc     = r_freq_inc;
    assign wave_sel     = r_wave_sel;
    assign amplitude    = r_amplitude;
    assign phase_reset  = r_phase_reset;
    assign param_update = r_param_update;

    // ------------------------------------------------------------------------
    // Invalid-command counter (optional)
    // ------------------------------------------------------------------------
`ifdef OSC_CMD_ERRCNT_EN
    logic             w_invalid;
    logic [ERR_W-1:0] r_err_count;

    // Addresses above SYNC are unmapped except SOFT_RST, which needs the key
    assign w_invalid = r_cmd_valid &&
                       (w_addr > ADDR_SYNC) &&
                       !((w_addr == ADDR_SOFT_RST) && w_key_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_invalid && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule : osc_cmd_decoder
`default_nettype wire

// File: tb/tb_osc_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_osc_cmd_decoder
// Description : Self-checking bench for osc_cmd_decoder. A table of command
//               words with hand-computed register values is applied one word
//               at a time, followed by directed sequences for held data_valid,
//               error-count saturation and reset interaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_cmd_decoder;

    logic        clock;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic [23:0] freq_inc;
    logic [1:0]  wave_sel;
    logic [11:0] amplitude;
    logic        phase_reset;
    logic        param_update;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    osc_cmd_decoder dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .freq_inc     (freq_inc),
        .wave_sel     (wave_sel),
        .amplitude    (amplitude),
        .phase_reset  (phase_reset),
        .param_update (param_update),
        .err_count    (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] word;
        logic [23:0] freq;
        logic [1:0]  wave;
        logic [11:0] amp;
        logic        pu;
        logic        pr;
        logic        inv;
    } vec_t;

    vec_t       vecs [14];
    logic [7:0] exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected error count after one more command with the given validity
    function automatic logic [7:0] next_err(input logic [7:0] cur, input logic inv);
`ifdef OSC_CMD_ERRCNT_EN
        if (inv && cur != 8'hFF) return cur + 8'd1;
        return cur;
`else
        return 8'h00;
`endif
    endfunction

    // Present one word for one clock; returns the pulses seen after the
    // capture edge and leaves time 1 unit after the decode edge.
    task automatic apply(input logic [15:0] w, output logic early_pu, output logic early_pr);
        @(negedge clock);
        data_in    = w;
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
        early_pu   = param_update;
        early_pr   = phase_reset;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic e_pu, e_pr;
        int   pu_cnt, pr_cnt;

        //                 word      freq        wave   amp      pu    pr    inv
        vecs[0]  = '{16'h0000, 24'h001000, 2'd0, 12'hFFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h1345, 24'h001000, 2'd0, 12'hFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h2012, 24'h012345, 2'd0, 12'hFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h2ABC, 24'hABC345, 2'd0, 12'hFFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h3FFE, 24'hABC345, 2'd2, 12'hFFF, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h3002, 24'hABC345, 2'd2, 12'hFFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h4800, 24'hABC345, 2'd2, 12'h800, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'h5000, 24'hABC345, 2'd2, 12'h800, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h7000, 24'hABC345, 2'd2, 12'h800, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{16'hE123, 24'hABC345, 2'd2, 12'h800, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16'hF123, 24'hABC345, 2'd2, 12'h800, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'hFA5A, 24'h001000, 2'd0, 12'hFFF, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{16'h2ABC, 24'hABC000, 2'd0, 12'hFFF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{16'h6FFF, 24'hABC000, 2'd0, 12'hFFF, 1'b0, 1'b0, 1'b1};

        reset      = 1'b1;
        data_in    = 16'h0000;
        data_valid = 1'b0;
        exp_err    = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        chk("reset_freq", 32'(freq_inc), 32'h001000);
        chk("reset_wave", 32'(wave_sel), 32'h0);
        chk("reset_amp",  32'(amplitude), 32'hFFF);
        chk("reset_pu",   32'(param_update), 32'h0);
        chk("reset_pr",   32'(phase_reset), 32'h0);
        chk("reset_err",  32'(err_count), 32'h0);

        // ---------------- table-driven single words ----------------
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].word, e_pu, e_pr);
            exp_err = next_err(exp_err, vecs[i].inv);
            chk($sformatf("v%0d_early_pu", i), 32'(e_pu), 32'h0);
            chk($sformatf("v%0d_early_pr", i), 32'(e_pr), 32'h0);
            chk($sformatf("v%0d_freq", i), 32'(freq_inc), 32'(vecs[i].freq));
            chk($sformatf("v%0d_wave", i), 32'(wave_sel), 32'(vecs[i].wave));
            chk($sformatf("v%0d_amp", i),  32'(amplitude), 32'(vecs[i].amp));
            chk($sformatf("v%0d_pu", i),   32'(param_update), 32'(vecs[i].pu));
            chk($sformatf("v%0d_pr", i),   32'(phase_reset), 32'(vecs[i].pr));
            chk($sformatf("v%0d_err", i),  32'(err_count), 32'(exp_err));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_pu_end", i), 32'(param_update), 32'h0);
            chk($sformatf("v%0d_pr_end", i), 32'(phase_reset), 32'h0);
        end

        // ---------------- data_valid held high for 10 clocks ----------------
        pu_cnt = 0;
        @(negedge clock);
        data_in    = 16'h4123;
        data_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            if (param_update) pu_cnt++;
            if (c == 9) data_valid = 1'b0;
        end
        chk("held_amp", 32'(amplitude), 32'h123);
        chk("held_pu_count", 32'(pu_cnt), 32'd1);

        // ---------------- 300 invalid words ----------------
        for (int n = 0; n < 300; n++) begin
            apply(16'h7000, e_pu, e_pr);
            exp_err = next_err(exp_err, 1'b1);
        end
        @(posedge clock);
        #1;
        chk("sat_err",  32'(err_count), 32'(exp_err));
        chk("sat_freq", 32'(freq_inc), 32'hABC000);
        chk("sat_wave", 32'(wave_sel), 32'h0);
        chk("sat_amp",  32'(amplitude), 32'h123);

        // ---------------- data_valid high through a reset pulse ----------------
        @(negedge clock);
        reset      = 1'b1;
        data_in    = 16'h4456;
        data_valid = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        pu_cnt = 0;
        pr_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            if (param_update) pu_cnt++;
            if (phase_reset) pr_cnt++;
        end
        data_valid = 1'b0;
        chk("hold_rst_amp", 32'(amplitude), 32'hFFF);
        chk("hold_rst_pu",  32'(pu_cnt), 32'd0);
        chk("hold_rst_err", 32'(err_count), 32'h0);

        // ---------------- reset while a word is in stage 1 ----------------
        @(negedge clock);
        data_in    = 16'h3002;
        data_valid = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        data_valid = 1'b0;
        pu_cnt     = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (param_update) pu_cnt++;
        end
        chk("mid_rst_wave", 32'(wave_sel), 32'h0);
        chk("mid_rst_pu",   32'(pu_cnt), 32'd0);

        // ---------------- decoder resumes normally ----------------
        apply(16'h3001, e_pu, e_pr);
        chk("resume_wave", 32'(wave_sel), 32'h1);
        chk("resume_pu",   32'(param_update), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_osc_cmd_decoder
`default_nettype wire
